data_mem_resp: RTL and testbench

Data-memory responder for the RISC-V core: the memory side of the core's load/store interface (address from ALUResult, store data from WriteData, load data to ReadData). It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait cycles. It performs byte/half/word stores with lane masking, and returns sign- or zero-extended load data. Misaligned or out-of-range accesses are flagged as errors.

---
 rtl/data_mem_resp.sv | 144 ++++++++++++++
 tb/tb_data_mem_resp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// Data-memory responder for the RISC-V core: one load/store at a time over a
// valid/ready handshake, LATENCY wait cycles, lane-masked stores, extended loads.
module data_mem_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             size_ok, align_ok, range_ok, err;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_lanes;
    logic [31:0]      rword, load_data;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;

    assign accept    = req_valid && (state == IDLE);
    assign idx       = req_addr[IDX_W+1:2];
    assign lane      = req_addr[1:0];
    assign range_ok  = (req_addr >> (IDX_W + 2)) == 32'd0;
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        size_ok  = 1'b0;
        align_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: begin size_ok = 1'b1; align_ok = 1'b1;            end
            3'b001, 3'b101: begin size_ok = 1'b1; align_ok = ~lane[0];        end
            3'b010:         begin size_ok = 1'b1; align_ok = (lane == 2'b00); end
            default: ;
        endcase
        // Unsigned variants exist only for loads.
        if (req_we && req_funct3[2]) size_ok = 1'b0;
    end

    assign err = !(size_ok && align_ok && range_ok);

    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                byte_en     = 4'b0001 << lane;
                wdata_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en     = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{req_wdata[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: ;
        endcase
    end

    assign rword     = mem[idx];
    assign load_half = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (lane)
            2'd0:    load_byte = rword[7:0];
            2'd1:    load_byte = rword[15:8];
            2'd2:    load_byte = rword[23:16];
            default: load_byte = rword[31:24];
        endcase
        case (req_funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b010:  load_data = rword;
            3'b100:  load_data = {24'd0, load_byte};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = 32'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: if (accept) begin
                state_next = (LATENCY == 0) ? RESP : WAIT;
                count_next = WAIT_INIT;
            end
            WAIT: if (count == 4'd0) state_next = RESP;
                  else               count_next = count - 4'd1;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The response is resolved at acceptance and held until the next request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_err   <= err;
            rsp_rdata <= (err || req_we) ? 32'd0 : load_data;
        end
    end

    // NOTE: the array has no reset; clearing it would force flops instead of RAM.
    always_ff @(posedge clk) begin
        if (accept && req_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: one LATENCY=2 and one LATENCY=0 instance
// checked against a byte-array reference model.
module tb_data_mem_resp;
    localparam int DEPTH = 256;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic [31:0] rsp_rdata [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem_model [2][DEPTH*4];

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-level reference: size from funct3, reject bad codes, misalignment and range.
    function automatic void model(input int s, input bit we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [2:0] f3,
                                  output logic [31:0] rd, output logic er);
        int          size;
        logic [31:0] v;
        rd = 32'd0;
        er = 1'b0;
        v  = 32'd0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (we && f3[2]) size = 0;
        if (size == 0 || (a % size) != 0 || a >= DEPTH * 4) begin
            er = 1'b1;
            return;
        end
        if (we) begin
            for (int i = 0; i < size; i++) mem_model[s][a+i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) v[8*i +: 8] = mem_model[s][a+i];
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
            rd = v;
        end
    endfunction

    task automatic txn(input int s, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input int hold, input bit early, input string tag);
        logic [31:0] erd;
        logic        eer;
        int          lat;
        model(s, we, a, wd, f3, erd, eer);
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
        req_valid[s] = 1'b1;
        lat = 0;
        while (!req_ready[s] && lat < 20) begin @(negedge clk); lat++; end
        @(negedge clk);
        req_valid[s] = 1'b0;
        if (early) rsp_ready[s] = 1'b1;
        check({tag, " req_ready busy"}, 32'(req_ready[s]), 32'd0);
        lat = 0;
        while (!rsp_valid[s] && lat < 40) begin @(negedge clk); lat++; end
        check({tag, " latency"}, 32'(lat + 1), (s == 0) ? 32'(LAT_A + 1) : 32'(LAT_B + 1));
        check({tag, " rdata"}, rsp_rdata[s], erd);
        check({tag, " err"}, 32'(rsp_err[s]), 32'(eer));
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            if (h == 1) begin
                req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'b010;
                req_valid[s] = 1'b1;
            end else if (h == 2) begin
                req_valid[s] = 1'b0;
            end
            check({tag, " hold valid"}, 32'(rsp_valid[s]), 32'd1);
            check({tag, " hold rdata"}, rsp_rdata[s], erd);
            check({tag, " hold err"}, 32'(rsp_err[s]), 32'(eer));
            check({tag, " hold req_ready"}, 32'(req_ready[s]), 32'd0);
        end
        req_valid[s] = 1'b0;
        rsp_ready[s] = 1'b1;
        @(negedge clk);
        rsp_ready[s] = 1'b0;
        check({tag, " rsp_valid drop"}, 32'(rsp_valid[s]), 32'd0);
    endtask

    initial begin
        logic [31:0] erd;
        logic        eer;
        bit          seen;
        logic [31:0] addr;

        reset = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
        #12;
        check("reset req_ready", 32'(req_ready), 32'd3);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset rdata a", rsp_rdata[0], 32'd0);
        check("reset rdata b", rsp_rdata[1], 32'd0);
        #5 reset = 1'b0;

        // Give the randomized region known contents in both instances.
        for (int w = 0; w < 32; w++) begin
            for (int s = 0; s < 2; s++) txn(s, 1'b1, 32'(w * 4), $urandom, 3'b010, 0, 1'b0, "fill");
        end

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 1'b0, "sw_10");
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0, "lw_10");
        txn(0, 1'b0, 32'h13, 32'h0, 3'b000, 0, 1'b0, "lb_13");
        txn(0, 1'b0, 32'h13, 32'h0, 3'b100, 0, 1'b0, "lbu_13");
        txn(0, 1'b0, 32'h12, 32'h0, 3'b001, 0, 1'b0, "lh_12");
        txn(0, 1'b0, 32'h10, 32'h0, 3'b101, 0, 1'b0, "lhu_10");
        txn(0, 1'b1, 32'h11, 32'h12345655, 3'b000, 0, 1'b0, "sb_11");
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0, "lw_after_sb");
        txn(0, 1'b1, 32'h12, 32'h00007777, 3'b001, 0, 1'b0, "sh_12");
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0, "lw_after_sh");
        model(0, 1'b0, 32'h10, 32'h0, 3'b010, erd, eer);
        check("model lw_10 value", erd, 32'h777755EF);
        txn(0, 1'b0, 32'h11, 32'h0, 3'b010, 0, 1'b0, "lw_mis");
        txn(0, 1'b1, 32'h13, 32'hFFFF, 3'b001, 0, 1'b0, "sh_mis");
        txn(0, 1'b0, 32'h400, 32'h0, 3'b010, 0, 1'b0, "lw_range");
        txn(0, 1'b1, 32'h400, 32'h1, 3'b010, 0, 1'b0, "sw_range");
        txn(0, 1'b0, 32'h10, 32'h0, 3'b011, 0, 1'b0, "f3_011");
        txn(0, 1'b1, 32'h10, 32'h0, 3'b100, 0, 1'b0, "sbu_bad");
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 5, 1'b0, "hold");
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b1, "lw_after_hold");

        // Reset during WAIT of a store: response dropped, write kept.
        model(0, 1'b1, 32'h20, 32'hA5A5A5A5, 3'b010, erd, eer);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_funct3 = 3'b010;
        req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("rst wait req_ready", 32'(req_ready[0]), 32'd0);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        check("rst idle req_ready", 32'(req_ready[0]), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid[0]) seen = 1'b1;
        end
        check("rst rsp dropped", 32'(seen), 32'd0);
        txn(0, 1'b0, 32'h20, 32'h0, 3'b010, 0, 1'b0, "lw_after_rst");

        txn(1, 1'b1, 32'h40, 32'h8000_7F81, 3'b010, 0, 1'b0, "l0_sw");
        txn(1, 1'b0, 32'h40, 32'h0, 3'b000, 0, 1'b0, "l0_lb");
        txn(1, 1'b0, 32'h42, 32'h0, 3'b001, 0, 1'b1, "l0_lh");

        for (int i = 0; i < 150; i++) begin
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 9) == 0) addr = $urandom;
                else                           addr = 32'($urandom_range(0, 127));
                txn(s, 1'($urandom_range(0, 1)), addr, $urandom, 3'($urandom_range(0, 7)),
                    0, 1'($urandom_range(0, 1)), "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
